// File: rtl/carry_chain_pkg.sv
// Shared types and helpers for the pipelined carry-chain adder.
// The entry record here is sized at the default width; the top re-declares it at its own WIDTH.
package carry_chain_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_SEG   = 8;

    function automatic int stages(input int width, input int seg);
        return (seg > 0) ? (width / seg) : 0;
    endfunction

    typedef struct packed {
        logic                 valid;
        logic [DEF_WIDTH-1:0] a_rem;
        logic [DEF_WIDTH-1:0] b_rem;
        logic                 carry;
        logic [DEF_WIDTH-1:0] sum_done;
    } stage_rec_t;

endpackage

// File: rtl/carry_chain_seg.sv
// Combinational SEG-bit ripple segment built from 1-bit carry cells.
// c_msb is the carry into the top bit, needed for signed overflow in the last stage.
module carry_chain_seg #(
    parameter int SEG = 8
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           cin,
    output logic [SEG-1:0] sum,
    output logic           cout,
    output logic           c_msb
);

    logic [SEG:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < SEG; i++) begin : g_bit
        assign sum[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout  = c[SEG];
    assign c_msb = c[SEG-1];

endmodule

// File: rtl/carry_chain_pipe_adder.sv
// Pipelined WIDTH-bit add/subtract: one SEG-bit ripple segment resolved per register stage,
// with valid/ready handshake and a single global stall that freezes every stage.
module carry_chain_pipe_adder
    import carry_chain_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SEG   = DEF_SEG
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int STAGES = stages(WIDTH, SEG);

    if (SEG < 1 || WIDTH < SEG || (WIDTH % SEG) != 0) begin : g_bad_params
        $fatal(1, "carry_chain_pipe_adder: WIDTH (%0d) must be a positive multiple of SEG (%0d)", WIDTH, SEG);
    end

    typedef struct packed {
        logic             valid;
        logic [WIDTH-1:0] a_rem;
        logic [WIDTH-1:0] b_rem;
        logic             carry;
        logic [WIDTH-1:0] sum_done;
    } stage_t;

    stage_t         in_rec;
    stage_t         src      [STAGES];
    stage_t         stage_d  [STAGES];
    stage_t         stage_q  [STAGES];
    logic [SEG-1:0] seg_a    [STAGES];
    logic [SEG-1:0] seg_b    [STAGES];
    logic [SEG-1:0] seg_sum  [STAGES];
    logic           seg_cin  [STAGES];
    logic           seg_cout [STAGES];
    logic           seg_cmsb [STAGES];
    logic           stall;
    logic           en;
    logic           ovf_d;
    logic           ovf_q;

    assign stall    = stage_q[STAGES-1].valid & ~out_ready;
    assign en       = ~stall;
    assign in_ready = ~stall;

    // Subtraction is a + ~b + 1, so the carry-in is forced high and cin is ignored.
    always_comb begin
        in_rec          = '0;
        in_rec.valid    = in_valid;
        in_rec.a_rem    = a;
        in_rec.b_rem    = sub ? ~b : b;
        in_rec.carry    = sub ? 1'b1 : cin;
        in_rec.sum_done = '0;
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_first
            assign src[k] = in_rec;
        end else begin : g_next
            assign src[k] = stage_q[k-1];
        end

        assign seg_a[k]   = src[k].a_rem[k*SEG +: SEG];
        assign seg_b[k]   = src[k].b_rem[k*SEG +: SEG];
        assign seg_cin[k] = src[k].carry;

        carry_chain_seg #(.SEG(SEG)) u_seg (
            .a     (seg_a[k]),
            .b     (seg_b[k]),
            .cin   (seg_cin[k]),
            .sum   (seg_sum[k]),
            .cout  (seg_cout[k]),
            .c_msb (seg_cmsb[k])
        );
    end

    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            stage_d[k]                        = src[k];
            stage_d[k].sum_done[k*SEG +: SEG] = seg_sum[k];
            stage_d[k].carry                  = seg_cout[k];
        end
        ovf_d = seg_cmsb[STAGES-1] ^ seg_cout[STAGES-1];
    end

    // Stage registers: reset clears everything, a stall freezes every stage together.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                stage_q[k] <= '0;
            end
            ovf_q <= 1'b0;
        end else if (en) begin
            for (int k = 0; k < STAGES; k++) begin
                stage_q[k] <= stage_d[k];
            end
            ovf_q <= ovf_d;
        end
    end

    assign out_valid = stage_q[STAGES-1].valid;
    assign sum       = stage_q[STAGES-1].sum_done;
    assign cout      = stage_q[STAGES-1].carry;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_carry_chain_pipe_adder.sv
// Scoreboard bench: an 8-bit/4-bit-segment instance and a 32-bit/8-bit-segment instance
// driven with directed vectors; monitors pop expected results whenever an output transfer occurs.
module tb_carry_chain_pipe_adder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        iv8 = 1'b0, ir8, cin8 = 1'b0, sub8 = 1'b0, ov8, or8 = 1'b1, co8, of8;
    logic [7:0]  a8 = '0, b8 = '0, s8;
    logic        iv32 = 1'b0, ir32, cin32 = 1'b0, sub32 = 1'b0, ov32, or32 = 1'b1, co32, of32;
    logic [31:0] a32 = '0, b32 = '0, s32;

    carry_chain_pipe_adder #(.WIDTH(8), .SEG(4)) dut8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8), .cin(cin8), .sub(sub8),
        .out_valid(ov8), .out_ready(or8), .sum(s8), .cout(co8), .ovf(of8)
    );

    carry_chain_pipe_adder #(.WIDTH(32), .SEG(8)) dut32 (
        .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32), .a(a32), .b(b32), .cin(cin32), .sub(sub32),
        .out_valid(ov32), .out_ready(or32), .sum(s32), .cout(co32), .ovf(of32)
    );

    int n_pass  = 0;
    int n_total = 0;

    logic [9:0]  q8  [$];
    logic [33:0] q32 [$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    endtask

    task automatic fail_now(input string nm);
        n_total++;
        $display("FAIL %s (t=%0t)", nm, $time);
    endtask

    function automatic logic [33:0] model32(input logic [31:0] a, input logic [31:0] b,
                                            input logic ci, input logic sb);
        logic [31:0] bb;
        logic [32:0] t;
        logic        v;
        bb = sb ? ~b : b;
        t  = {1'b0, a} + {1'b0, bb} + {32'd0, (sb ? 1'b1 : ci)};
        v  = (a[31] == bb[31]) && (t[31] != a[31]);
        return {v, t[32], t[31:0]};
    endfunction

    // Monitors: handshake relation, stall stability and in-order result delivery.
    logic       hold8 = 1'b0, hold32 = 1'b0;
    logic [10:0] held8;
    logic [34:0] held32;
    int         stall8_cnt = 0;

    always @(negedge clk) begin
        if (rst) begin
            hold8 = 1'b0;
        end else begin
            chk("in_ready8", {63'd0, ir8}, {63'd0, !(ov8 && !or8)});
            if (!ir8) stall8_cnt++;
            if (hold8) chk("hold8", {53'd0, ov8, of8, co8, s8}, {53'd0, held8});
            if (ov8 && or8) begin
                if (q8.size() == 0) fail_now("unexpected8 output emitted");
                else chk("result8", {54'd0, of8, co8, s8}, {54'd0, q8.pop_front()});
            end
            hold8 = ov8 && !or8;
            held8 = {ov8, of8, co8, s8};
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            hold32 = 1'b0;
        end else begin
            chk("in_ready32", {63'd0, ir32}, {63'd0, !(ov32 && !or32)});
            if (hold32) chk("hold32", {29'd0, ov32, of32, co32, s32}, {29'd0, held32});
            if (ov32 && or32) begin
                if (q32.size() == 0) fail_now("unexpected32 output emitted");
                else chk("result32", {30'd0, of32, co32, s32}, {30'd0, q32.pop_front()});
            end
            hold32 = ov32 && !or32;
            held32 = {ov32, of32, co32, s32};
        end
    end

    // Drivers present one operand set and push its expectation at the accepting cycle.
    task automatic drive8(input logic [7:0] a, input logic [7:0] b, input logic ci, input logic sb,
                          input logic [7:0] es, input logic ec, input logic eo);
        int n;
        a8 = a; b8 = b; cin8 = ci; sub8 = sb; iv8 = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (ir8) begin q8.push_back({eo, ec, es}); break; end
            n++;
            if (n > 100) begin fail_now("drive8 timeout"); break; end
        end
        @(posedge clk); #1;
        iv8 = 1'b0;
    endtask

    task automatic drive32(input logic [31:0] a, input logic [31:0] b, input logic ci, input logic sb,
                           input logic [33:0] exp);
        int n;
        a32 = a; b32 = b; cin32 = ci; sub32 = sb; iv32 = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (ir32) begin q32.push_back(exp); break; end
            n++;
            if (n > 100) begin fail_now("drive32 timeout"); break; end
        end
        @(posedge clk); #1;
        iv32 = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((q8.size() != 0 || q32.size() != 0) && n < 200) begin
            @(posedge clk);
            n++;
        end
        if (n >= 200) begin
            fail_now("drain timeout");
            q8.delete();
            q32.delete();
        end
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic        rc, rs;

        // Reset held two edges with in_valid asserted.
        rst = 1'b1; iv8 = 1'b1; a8 = 8'h11; b8 = 8'h22; iv32 = 1'b1; a32 = 32'h1234; b32 = 32'h1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_out_valid8", {63'd0, ov8}, 64'd0);
        chk("rst_sum8",       {56'd0, s8}, 64'd0);
        chk("rst_cout8",      {63'd0, co8}, 64'd0);
        chk("rst_ovf8",       {63'd0, of8}, 64'd0);
        chk("rst_in_ready8",  {63'd0, ir8}, 64'd1);
        chk("rst_out_valid32", {63'd0, ov32}, 64'd0);
        chk("rst_sum32",       {32'd0, s32}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0; iv8 = 1'b0; iv32 = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        // Single op latency plus cross-segment carry.
        drive8(8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0);
        @(negedge clk);
        chk("latency8_not_yet", {63'd0, ov8}, 64'd0);
        @(negedge clk);
        chk("latency8_valid", {63'd0, ov8}, 64'd1);
        @(posedge clk); #1;

        drive8(8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
        drive8(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        drive8(8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0);
        wait_drain();

        // Five back-to-back ops with out_ready low in cycles 3-6.
        stall8_cnt = 0;
        fork
            begin
                drive8(8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0);
                drive8(8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
                drive8(8'h55, 8'hAA, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
                drive8(8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1, 1'b0);
                drive8(8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);
            end
            begin
                repeat (3) @(posedge clk);
                #1 or8 = 1'b0;
                repeat (4) @(posedge clk);
                #1 or8 = 1'b1;
            end
        join
        wait_drain();
        chk("stall8_cycles", 64'(stall8_cnt), 64'd4);

        // Reset while two ops are in flight: neither may emerge.
        a8 = 8'h21; b8 = 8'h21; cin8 = 1'b0; sub8 = 1'b0; iv8 = 1'b1;
        @(posedge clk); #1;
        a8 = 8'h42; b8 = 8'h01; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; iv8 = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("flush8_no_valid", {63'd0, ov8}, 64'd0);
        end
        @(posedge clk); #1;
        drive8(8'h3C, 8'h0C, 1'b0, 1'b0, 8'h48, 1'b0, 1'b0);
        wait_drain();

        // 32-bit directed boundaries.
        drive32(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, {1'b0, 1'b1, 32'h0000_0000});
        drive32(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, {1'b1, 1'b0, 32'h8000_0000});
        drive32(32'h00FF_00FF, 32'h0001_0001, 1'b0, 1'b0, {1'b0, 1'b0, 32'h0100_0100});
        drive32(32'h0000_0000, 32'h0000_0001, 1'b1, 1'b1, {1'b0, 1'b0, 32'hFFFF_FFFF});
        drive32(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, {1'b1, 1'b1, 32'h7FFF_FFFF});
        wait_drain();

        // 32-bit random operands against the reference model under random backpressure.
        fork
            begin
                for (int i = 0; i < 12; i++) begin
                    ra = $urandom; rb = $urandom; rc = 1'($urandom_range(0, 1)); rs = 1'($urandom_range(0, 1));
                    drive32(ra, rb, rc, rs, model32(ra, rb, rc, rs));
                end
            end
            begin
                repeat (30) begin
                    @(posedge clk);
                    #1 or32 = 1'($urandom_range(0, 1));
                end
                or32 = 1'b1;
            end
        join
        or32 = 1'b1;
        wait_drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired (t=%0t)", $time);
        $fatal(1, "watchdog");
    end

endmodule
